mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 179 +++++++++++++++++
 tb/tb_mc_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control FSM with NZCV flags and condition evaluation.
// Build option MC_CTRL_CMP_EN adds CMP (cmd 1010) as a flag-only compare that skips ALUWB.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  State
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  state_t     state, state_next;
  logic [3:0] flags;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       i_bit, s_bit, u_bit, rd15, cond_ex, in_exec, flag_we;
  logic [2:0] cmd_alu;
  logic       cmd_ok, cmd_arith, cmd_cmp;
  logic       pc_we, mem_we, ir_we, reg_we;
  logic       unused_instr;

  assign op    = Instr[27:26];
  assign i_bit = Instr[25];
  assign cmd   = Instr[24:21];
  assign u_bit = Instr[23];
  assign s_bit = Instr[20];
  assign rd15  = (Instr[15:12] == 4'hF);
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cond_ex = cond_pass(Instr[31:28], flags);

  // cmd_ok low marks an unsupported data-processing cmd: no register, PC or flag writes
  always_comb begin
    cmd_alu   = ALU_ADD;
    cmd_ok    = 1'b0;
    cmd_arith = 1'b0;
    cmd_cmp   = 1'b0;
    case (cmd)
      4'b0100: begin cmd_ok = 1'b1; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = ALU_SUB; cmd_ok = 1'b1; cmd_arith = 1'b1; end
      4'b0000: begin cmd_alu = ALU_AND; cmd_ok = 1'b1; end
      4'b1100: begin cmd_alu = ALU_ORR; cmd_ok = 1'b1; end
`ifdef MC_CTRL_CMP_EN
      4'b1010: begin cmd_alu = ALU_SUB; cmd_ok = 1'b1; cmd_arith = 1'b1; cmd_cmp = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign in_exec = (state == EXECR) || (state == EXECI);
  assign flag_we = in_exec && cmd_ok && cond_ex && (s_bit || cmd_cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags[3:2] <= ALUFlags[3:2];
      if (cmd_arith) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          2'b00:   state_next = i_bit ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = s_bit ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      EXECR,
      EXECI:  state_next = cmd_cmp ? FETCH : ALUWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        ir_we = 1'b1; pc_we = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ALUControl = u_bit ? ALU_ADD : ALU_SUB;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc = 1'b1; mem_we = cond_ex;
      end
      MEMWB: begin
        ResultSrc = 2'b01; reg_we = cond_ex; pc_we = cond_ex & rd15;
      end
      EXECR: ALUControl = cmd_alu;
      EXECI: begin
        ALUSrcB = 2'b01; ALUControl = cmd_alu;
      end
      ALUWB: begin
        reg_we = cond_ex & cmd_ok; pc_we = cond_ex & cmd_ok & rd15;
      end
      BRANCH: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_we = cond_ex;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pc_we  & ~reset;
  assign MemWrite = mem_we & ~reset;
  assign IRWrite  = ir_we  & ~reset;
  assign RegWrite = reg_we & ~reset;
  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};
  assign State    = state;
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues hand-computed per-cycle control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_controller;
  logic        clk, reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] imm, rsrc;
  } rec_t;

  rec_t  eq[$];
  string tq[$];
  int    checks = 0;
  int    failures = 0;
  logic [1:0] exp_imm, exp_rsrc;
  rec_t  mon_e, mon_a;
  string mon_t;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (eq.size() > 0) begin
      mon_e = eq.pop_front();
      mon_t = tq.pop_front();
      mon_a.st = State;   mon_a.pcw = PCWrite; mon_a.adr = AdrSrc; mon_a.mw = MemWrite;
      mon_a.irw = IRWrite; mon_a.rw = RegWrite; mon_a.rs = ResultSrc; mon_a.sa = ALUSrcA;
      mon_a.sb = ALUSrcB; mon_a.alu = ALUControl; mon_a.imm = ImmSrc; mon_a.rsrc = RegSrc;
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL %s st%0d: got {st,pcw,adr,mw,irw,rw,rs,sa,sb,alu,imm,rsrc}=%b required %b",
                 mon_t, mon_e.st, mon_a, mon_e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic cyc(input string tag, input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                     input logic [1:0] rs, input logic sa, input logic [1:0] sb, input logic [2:0] alu);
    rec_t r;
    r.st = st; r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw; r.rw = rw;
    r.rs = rs; r.sa = sa; r.sb = sb; r.alu = alu; r.imm = exp_imm; r.rsrc = exp_rsrc;
    eq.push_back(r);
    tq.push_back(tag);
    @(posedge clk); #1;
  endtask

  task automatic set_i(input logic [31:0] i, input logic [3:0] af, input logic [1:0] imm, rsrc);
    Instr = i; ALUFlags = af; exp_imm = imm; exp_rsrc = rsrc;
  endtask

  task automatic fetch(input string tag);
    cyc(tag, 4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'b000);
  endtask

  task automatic decode(input string tag);
    cyc(tag, 4'd1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000);
  endtask

  task automatic dp(input string tag, input logic [31:0] i, input logic [3:0] af, input logic [3:0] ex_st,
                    input logic [2:0] alu, input logic [1:0] sb, input logic rw, pcw);
    set_i(i, af, 2'b00, 2'b00);
    fetch(tag); decode(tag);
    cyc(tag, ex_st, 0, 0, 0, 0, 0, 2'b00, 0, sb, alu);
    cyc(tag, 4'd8, pcw, 0, 0, 0, rw, 2'b00, 0, 2'b00, 3'b000);
  endtask

  task automatic br(input string tag, input logic [31:0] i, input logic pcw);
    set_i(i, 4'b0000, 2'b10, 2'b01);
    fetch(tag); decode(tag);
    cyc(tag, 4'd9, pcw, 0, 0, 0, 0, 2'b10, 1, 2'b01, 3'b000);
  endtask

  task automatic ldr(input string tag, input logic [31:0] i, input logic [2:0] alu, input logic pcw);
    set_i(i, 4'b0000, 2'b01, 2'b10);
    fetch(tag); decode(tag);
    cyc(tag, 4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, alu);
    cyc(tag, 4'd3, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000);
    cyc(tag, 4'd4, pcw, 0, 0, 0, 1, 2'b01, 0, 2'b00, 3'b000);
  endtask

  task automatic str(input string tag, input logic [31:0] i, input logic rst_in_wr);
    set_i(i, 4'b0000, 2'b01, 2'b10);
    fetch(tag); decode(tag);
    cyc(tag, 4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000);
    reset = rst_in_wr;
    cyc(tag, 4'd5, 0, 1, !rst_in_wr, 0, 0, 2'b00, 0, 2'b00, 3'b000);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_i(32'hE0812003, 4'b0000, 2'b00, 2'b00);
    @(posedge clk); #1;
    cyc("reset", 4'd0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000);
    reset = 1'b0;

    dp("add_r", 32'hE0812003, 4'b0000, 4'd6, 3'b000, 2'b00, 1, 0);
    ldr("ldr", 32'hE5910004, 3'b000, 0);
    br("beq_z0", 32'h0A000002, 0);
    br("bne_z0", 32'h1A000002, 1);
    dp("subs", 32'hE0500000, 4'b0100, 4'd6, 3'b001, 2'b00, 1, 0);
    br("beq_z1", 32'h0A000002, 1);
    dp("adds_i", 32'hE2910000, 4'b1001, 4'd7, 3'b000, 2'b01, 1, 0);
    br("bmi_n1", 32'h4A000002, 1);
    br("beq_after_adds", 32'h0A000002, 0);
    br("bvs_v1", 32'h6A000002, 1);
    br("bge_nv", 32'hAA000002, 1);
    dp("ands", 32'hE0100000, 4'b0111, 4'd6, 3'b010, 2'b00, 1, 0);
    br("bcs_ckeep", 32'h2A000002, 0);
    br("beq_ands", 32'h0A000002, 1);
    br("bmi_ands", 32'h4A000002, 0);
    dp("orr_i", 32'hE3800001, 4'b1111, 4'd7, 3'b011, 2'b01, 1, 0);
    br("beq_no_s", 32'h0A000002, 1);
    dp("eor_unsup", 32'hE031F000, 4'b1000, 4'd6, 3'b000, 2'b00, 0, 0);
    br("beq_unsup", 32'h0A000002, 1);
    br("bmi_unsup", 32'h4A000002, 0);
    dp("add_nv", 32'hF0812003, 4'b0000, 4'd6, 3'b000, 2'b00, 0, 0);
    br("b_nv", 32'hFA000002, 0);
    dp("add_pc", 32'hE08FF003, 4'b0000, 4'd6, 3'b000, 2'b00, 1, 1);
    ldr("ldr_pc_sub", 32'hE510F004, 3'b001, 1);
    set_i(32'hEC000000, 4'b0000, 2'b11, 2'b00);
    fetch("undef"); decode("undef");
    str("str", 32'hE5810004, 1'b0);
    str("str_reset", 32'hE5810004, 1'b1);
    br("beq_post_rst", 32'h0A000002, 0);
    br("bne_post_rst", 32'h1A000002, 1);
`ifdef MC_CTRL_CMP_EN
    set_i(32'hE3510005, 4'b0100, 2'b00, 2'b00);
    fetch("cmp"); decode("cmp");
    cyc("cmp", 4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b001);
    br("beq_cmp", 32'h0A000002, 1);
`else
    dp("cmp_unsup", 32'hE3510005, 4'b0100, 4'd7, 3'b000, 2'b01, 0, 0);
    br("beq_cmp", 32'h0A000002, 0);
`endif

    for (int k = 0; k < 20 && eq.size() > 0; k++) @(posedge clk);
    checks++;
    if (eq.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected records left, required 0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
